// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs the imem req/ack handshake and
// feeds IF/ID from a 2-entry buffer. Optional build macro: IF_MISALIGN_TRAP_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_IF_ID,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_Instruction,
  output logic        IF_valid,
  output logic        IF_misalign
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] buf_pc_q [2];
  logic [31:0] buf_pc_d [2];
  logic [31:0] buf_instr_q [2];
  logic [31:0] buf_instr_d [2];

  logic [31:0] eff_target;
  logic        push;
  logic        pop;
  logic [1:0]  wr_slot;

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_q;

  assign eff_target = (redirect_target[1:0] != 2'b00) ? EXC_VECTOR : redirect_target;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= redirect && (redirect_target[1:0] != 2'b00);
    end
  end

  assign IF_misalign = misalign_q;
`else
  logic unused_cfg;

  assign eff_target  = {redirect_target[31:2], 2'b00};
  assign unused_cfg  = ^{EXC_VECTOR, redirect_target[1:0]};
  assign IF_misalign = 1'b0;
`endif

  // Request is a pure function of state, so it drops with the asynchronous reset.
  always_comb begin
    case (state_q)
      FETCH:   imem_req = (count_q != 2'd2);
      DRAIN:   imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  assign imem_addr = fetch_pc_q;
  assign IF_valid  = (count_q != 2'd0);
  assign pop       = IF_valid && !stall_IF_ID;
  assign push      = (state_q == FETCH) && imem_req && imem_ack && !redirect;
  assign wr_slot   = count_q - {1'b0, pop};

  // NOTE: every next-state variable gets its default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    count_d      = count_q;
    buf_pc_d     = buf_pc_q;
    buf_instr_d  = buf_instr_q;

    case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (redirect) fetch_pc_d = eff_target;
      end
      FETCH: begin
        if (redirect) begin
          if (imem_req && !imem_ack) begin
            pending_pc_d = eff_target;
            state_d      = DRAIN;
          end else begin
            fetch_pc_d = eff_target;
          end
        end else if (push) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      DRAIN: begin
        // The outstanding wrong-path word is thrown away; a same-cycle redirect wins.
        if (imem_ack) begin
          fetch_pc_d = redirect ? eff_target : pending_pc_q;
          state_d    = FETCH;
        end else if (redirect) begin
          pending_pc_d = eff_target;
        end
      end
      default: state_d = BOOT;
    endcase

    if (redirect) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        buf_pc_d[0]    = buf_pc_q[1];
        buf_instr_d[0] = buf_instr_q[1];
      end
      if (push) begin
        buf_pc_d[wr_slot[0]]    = fetch_pc_q;
        buf_instr_d[wr_slot[0]] = imem_rdata;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      count_q      <= count_d;
    end
  end

  // NOTE: buffer payload has no reset; count gates it, so stale contents are never visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      buf_pc_q[i]    <= buf_pc_d[i];
      buf_instr_q[i] <= buf_instr_d[i];
    end
  end

  assign IF_PC          = IF_valid ? buf_pc_q[0]    : 32'd0;
  assign IF_Instruction = IF_valid ? buf_instr_q[0] : 32'd0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed table-driven bench for if_fetch_unit; the instruction memory returns ~addr,
// so the expected instruction for a PC is simply its bitwise complement.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_IF_ID = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        imem_ack = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] IF_PC;
  logic [31:0] IF_Instruction;
  logic        IF_valid;
  logic        IF_misalign;

  int errors = 0;
  int checks = 0;

`ifdef IF_MISALIGN_TRAP_EN
  localparam logic [31:0] MB = 32'h0000_0080;
  localparam logic        MX = 1'b1;
`else
  localparam logic [31:0] MB = 32'h0000_0200;
  localparam logic        MX = 1'b0;
`endif

  if_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall_IF_ID    (stall_IF_ID),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .IF_PC          (IF_PC),
    .IF_Instruction (IF_Instruction),
    .IF_valid       (IF_valid),
    .IF_misalign    (IF_misalign)
  );

  always #5 clk = ~clk;

  assign imem_rdata = ~imem_addr;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic        ack;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic s, input logic r, input logic [31:0] t, input logic a,
                             input logic er, input logic [31:0] ea, input logic ev,
                             input logic [31:0] ep, input logic em);
    vec_t x;
    x.stall = s; x.redir = r; x.tgt = t; x.ack = a;
    x.exp_req = er; x.exp_addr = ea; x.exp_valid = ev; x.exp_pc = ep; x.exp_mis = em;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t x);
    check({tag, " req"}, {31'd0, imem_req}, {31'd0, x.exp_req});
    if (x.exp_req) check({tag, " addr"}, imem_addr, x.exp_addr);
    check({tag, " valid"}, {31'd0, IF_valid}, {31'd0, x.exp_valid});
    check({tag, " pc"}, IF_PC, x.exp_pc);
    check({tag, " instr"}, IF_Instruction, x.exp_valid ? ~x.exp_pc : 32'd0);
    check({tag, " misalign"}, {31'd0, IF_misalign}, {31'd0, x.exp_mis});
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic step(input string tag, input vec_t x);
    @(negedge clk);
    stall_IF_ID     = x.stall;
    redirect        = x.redir;
    redirect_target = x.tgt;
    imem_ack        = x.ack;
    #1;
    check_outs(tag, x);
  endtask

  initial begin
    //           stall redir tgt           ack  req addr          valid pc            mis
    tbl.push_back(v(0, 0, 32'h0,          1,   0, 32'h0,        0, 32'h0,        0)); // c0 BOOT
    tbl.push_back(v(0, 0, 32'h0,          1,   1, 32'h0,        0, 32'h0,        0)); // c1
    tbl.push_back(v(0, 0, 32'h0,          1,   1, 32'h4,        1, 32'h0,        0));
    tbl.push_back(v(1, 0, 32'h0,          1,   1, 32'h8,        1, 32'h4,        0)); // stall
    tbl.push_back(v(1, 0, 32'h0,          1,   0, 32'h0,        1, 32'h4,        0)); // full
    tbl.push_back(v(1, 0, 32'h0,          1,   0, 32'h0,        1, 32'h4,        0));
    tbl.push_back(v(0, 0, 32'h0,          1,   0, 32'h0,        1, 32'h4,        0)); // release
    tbl.push_back(v(0, 0, 32'h0,          1,   1, 32'hC,        1, 32'h8,        0));
    tbl.push_back(v(0, 0, 32'h0,          1,   1, 32'h10,       1, 32'hC,        0));
    tbl.push_back(v(0, 1, 32'h100,        1,   1, 32'h14,       1, 32'h10,       0)); // c9 redirect
    tbl.push_back(v(0, 0, 32'h0,          1,   1, 32'h100,      0, 32'h0,        0));
    tbl.push_back(v(0, 0, 32'h0,          0,   1, 32'h104,      1, 32'h100,      0));
    tbl.push_back(v(0, 1, 32'h200,        0,   1, 32'h104,      0, 32'h0,        0)); // -> DRAIN
    tbl.push_back(v(0, 0, 32'h0,          0,   1, 32'h104,      0, 32'h0,        0));
    tbl.push_back(v(0, 0, 32'h0,          0,   1, 32'h104,      0, 32'h0,        0));
    tbl.push_back(v(0, 0, 32'h0,          1,   1, 32'h104,      0, 32'h0,        0)); // drain ack
    tbl.push_back(v(0, 0, 32'h0,          1,   1, 32'h200,      0, 32'h0,        0));
    tbl.push_back(v(0, 0, 32'h0,          1,   1, 32'h204,      1, 32'h200,      0));
    tbl.push_back(v(0, 1, 32'h202,        1,   1, 32'h208,      1, 32'h204,      0)); // misaligned
    tbl.push_back(v(0, 0, 32'h0,          1,   1, MB,           0, 32'h0,        MX));
    tbl.push_back(v(0, 0, 32'h0,          1,   1, MB + 32'h4,   1, MB,           0));
    tbl.push_back(v(0, 1, 32'hFFFF_FFFC,  1,   1, MB + 32'h8,   1, MB + 32'h4,   0)); // wrap
    tbl.push_back(v(0, 0, 32'h0,          1,   1, 32'hFFFF_FFFC, 0, 32'h0,       0));
    tbl.push_back(v(0, 0, 32'h0,          1,   1, 32'h0,        1, 32'hFFFF_FFFC, 0));
    tbl.push_back(v(1, 1, 32'h300,        1,   1, 32'h4,        1, 32'h0,        0)); // stall+redirect
    tbl.push_back(v(0, 0, 32'h0,          1,   1, 32'h300,      0, 32'h0,        0));
    tbl.push_back(v(0, 0, 32'h0,          1,   1, 32'h304,      1, 32'h300,      0));

    // Reset state while held.
    repeat (2) @(negedge clk);
    check_outs("reset", v(0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 0));

    @(posedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("c%0d", i), tbl[i]);
    end

    // Redirects stacking up in DRAIN, the last one coinciding with the ack.
    step("d0", v(0, 1, 32'h400, 0,  1, 32'h308, 1, 32'h304, 0));
    step("d1", v(0, 1, 32'h500, 0,  1, 32'h308, 0, 32'h0,   0));
    step("d2", v(0, 1, 32'h600, 1,  1, 32'h308, 0, 32'h0,   0));
    step("d3", v(1, 0, 32'h0,   1,  1, 32'h600, 0, 32'h0,   0));
    step("d4", v(1, 0, 32'h0,   0,  1, 32'h604, 1, 32'h600, 0));

    // Reset mid-transaction, between clock edges.
    #2 reset = 1'b1;
    #1 check_outs("async_rst", v(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0));
    @(posedge clk);
    #2 reset = 1'b0;
    step("r0", v(0, 0, 32'h0, 1,  0, 32'h0, 0, 32'h0, 0));
    step("r1", v(0, 0, 32'h0, 1,  1, 32'h0, 0, 32'h0, 0));
    step("r2", v(0, 0, 32'h0, 1,  1, 32'h4, 1, 32'h0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
